// File: rtl/strobe_interval_meter_if.sv
// Measurement result channel: the meter presents interval/ovf/locked under a
// valid/ready handshake, and pulses dropped when an unconsumed result is overwritten.
interface strobe_interval_meter_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] interval;
  logic             interval_valid;
  logic             interval_ready;
  logic             ovf;
  logic             locked;
  logic             dropped;

  modport master (
    output interval, interval_valid, ovf, locked, dropped,
    input  interval_ready
  );

  modport slave (
    input  interval, interval_valid, ovf, locked, dropped,
    output interval_ready
  );
endinterface

// File: rtl/strobe_interval_meter.sv
// Counts enabled ticks between strobe events and reports each interval with
// saturation, lock detection (LOCK_COUNT equal intervals) and overwrite detection.
module strobe_interval_meter #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      strobe_in,
  strobe_interval_meter_if.master   m
);

  localparam logic [0:0]       ARM     = 1'b0;
  localparam logic [0:0]       MEASURE = 1'b1;
  localparam logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}};
  localparam logic [3:0]       LOCK    = 4'(LOCK_COUNT);

  logic [0:0]       state;
  logic [WIDTH-1:0] cnt;
  logic             sat;
  logic [WIDTH-1:0] prev;
  logic             prev_ovf;
  logic [3:0]       run;

  logic             at_max;
  logic             meas;
  logic [WIDTH-1:0] meas_val;
  logic             meas_ovf;
  logic             match;
  logic [3:0]       run_nxt;

  // The strobe cycle itself counts as a tick when enable is high.
  always_comb begin
    at_max   = (cnt == MAX);
    meas     = (state == MEASURE) && strobe_in;
    meas_val = cnt;
    meas_ovf = sat;
    if (enable) begin
      if (at_max) meas_ovf = 1'b1;
      else        meas_val = cnt + WIDTH'(1);
    end
    match   = (meas_val == prev) && !meas_ovf && !prev_ovf;
    run_nxt = meas_ovf ? 4'd0 : 4'd1;
    if (match) run_nxt = (run == LOCK) ? LOCK : run + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARM;
      cnt      <= '0;
      sat      <= 1'b0;
      prev     <= '0;
      prev_ovf <= 1'b0;
      run      <= '0;
    end else begin
      case (state)
        ARM: begin
          if (strobe_in) begin
            state <= MEASURE;
            cnt   <= '0;
            sat   <= 1'b0;
          end
        end
        default: begin
          if (strobe_in) begin
            cnt      <= '0;
            sat      <= 1'b0;
            prev     <= meas_val;
            prev_ovf <= meas_ovf;
            run      <= run_nxt;
          end else if (enable) begin
            if (at_max) sat <= 1'b1;
            else        cnt <= cnt + WIDTH'(1);
          end
        end
      endcase
    end
  end

  // A new result always wins; it counts as dropped only if the old one was
  // still pending and not being taken this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      m.interval       <= '0;
      m.interval_valid <= 1'b0;
      m.ovf            <= 1'b0;
      m.locked         <= 1'b0;
      m.dropped        <= 1'b0;
    end else if (meas) begin
      m.interval       <= meas_val;
      m.ovf            <= meas_ovf;
      m.locked         <= (run_nxt == LOCK);
      m.interval_valid <= 1'b1;
      m.dropped        <= m.interval_valid && !m.interval_ready;
    end else begin
      m.dropped <= 1'b0;
      if (m.interval_valid && m.interval_ready) m.interval_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_strobe_interval_meter.sv
// Directed bench for strobe_interval_meter: each step drives one cycle of
// inputs and checks the registered outputs just after the following edge.
module tb_strobe_interval_meter;
  localparam int WIDTH      = 4;
  localparam int LOCK_COUNT = 3;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic enable    = 1'b0;
  logic strobe_in = 1'b0;
  int   n_cmp     = 0;
  int   n_err     = 0;

  strobe_interval_meter_if #(.WIDTH(WIDTH)) bus ();

  strobe_interval_meter #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .strobe_in (strobe_in),
    .m         (bus.master)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic en, input logic stb, input logic rdy);
    @(negedge clk);
    rst                = r;
    enable             = en;
    strobe_in          = stb;
    bus.interval_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic en, input logic stb, input logic rdy);
    drive(1'b0, en, stb, rdy);
  endtask

  // ticks enabled cycles, then a strobe with enable low: interval == ticks
  task automatic gap(input int ticks, input logic rdy);
    repeat (ticks) step(1'b1, 1'b0, rdy);
    step(1'b0, 1'b1, rdy);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_meas(input string tag, input int ival, input logic ov, input logic lk);
    chk({tag, ".interval"}, 32'(bus.interval), 32'(ival));
    chk({tag, ".valid"},    32'(bus.interval_valid), 32'd1);
    chk({tag, ".ovf"},      32'(bus.ovf), 32'(ov));
    chk({tag, ".locked"},   32'(bus.locked), 32'(lk));
  endtask

  initial begin
    int gcnt;
    int nstb;
    logic en, stb;
    bus.interval_ready = 1'b1;

    // reset wins over strobe/enable/ready
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst.interval", 32'(bus.interval), 32'd0);
    chk("rst.valid",    32'(bus.interval_valid), 32'd0);
    chk("rst.ovf",      32'(bus.ovf), 32'd0);
    chk("rst.locked",   32'(bus.locked), 32'd0);
    chk("rst.dropped",  32'(bus.dropped), 32'd0);

    // enable held high, strobe every 5 cycles: 4 ticks + strobe-cycle tick = 5
    step(1'b1, 1'b1, 1'b1);
    chk("arm.valid", 32'(bus.interval_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      repeat (4) step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      chk_meas($sformatf("periodic%0d", k), 5, 1'b0, k == 2);
    end
    step(1'b0, 1'b0, 1'b1);
    chk("periodic.consumed", 32'(bus.interval_valid), 32'd0);

    // three equal intervals of 7 lock, an 8 breaks it
    gap(7, 1'b1); chk_meas("seven0", 7, 1'b0, 1'b0);
    gap(7, 1'b1); chk_meas("seven1", 7, 1'b0, 1'b0);
    gap(7, 1'b1); chk_meas("seven2", 7, 1'b0, 1'b1);
    gap(8, 1'b1); chk_meas("eight",  8, 1'b0, 1'b0);

    // saturation
    gap(20, 1'b1); chk_meas("sat20", 15, 1'b1, 1'b0);
    gap(4, 1'b1);  chk_meas("after_sat", 4, 1'b0, 1'b0);
    gap(15, 1'b1); chk_meas("exact15", 15, 1'b0, 1'b0);

    // zero-length intervals report 0 and can lock
    step(1'b0, 1'b1, 1'b1); chk_meas("zero0", 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1); chk_meas("zero1", 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1); chk_meas("zero2", 0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("zero.consumed", 32'(bus.interval_valid), 32'd0);

    // backpressure: 3 then 9 without ready overwrites and pulses dropped
    gap(3, 1'b0);
    chk_meas("bp3", 3, 1'b0, 1'b0);
    chk("bp3.dropped", 32'(bus.dropped), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("bp.hold", 32'(bus.interval), 32'd3);
    repeat (8) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk_meas("bp9", 9, 1'b0, 1'b0);
    chk("bp9.dropped", 32'(bus.dropped), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("bp.dropped_clr", 32'(bus.dropped), 32'd0);
    chk("bp.still_valid", 32'(bus.interval_valid), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("bp.consumed", 32'(bus.interval_valid), 32'd0);

    // handshake in the same cycle as a new result: reload, no drop
    gap(2, 1'b0);
    chk_meas("hs_first", 2, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk_meas("hs_same", 2, 1'b0, 1'b0);
    chk("hs_same.dropped", 32'(bus.dropped), 32'd0);
    step(1'b0, 1'b0, 1'b1);

    // reset mid-measurement discards the partial count and re-arms
    repeat (4) step(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    chk("midrst.valid", 32'(bus.interval_valid), 32'd0);
    step(1'b0, 1'b1, 1'b1);
    chk("midrst.arm_only", 32'(bus.interval_valid), 32'd0);
    gap(2, 1'b1);
    chk_meas("midrst.two", 2, 1'b0, 1'b0);

    // divide-by-5 strobe source, enable every other cycle
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    gcnt = 0;
    nstb = 0;
    for (int c = 0; c < 52; c++) begin
      en  = (c % 2) == 1;
      stb = en && (gcnt == 4);
      if (en) gcnt = (gcnt == 4) ? 0 : gcnt + 1;
      step(en, stb, 1'b1);
      if (stb) begin
        nstb++;
        if (nstb == 1) chk("div.arm", 32'(bus.interval_valid), 32'd0);
        else chk_meas($sformatf("div%0d", nstb - 1), 5, 1'b0, (nstb - 1) >= 3);
      end
    end
    chk("div.count", 32'(nstb), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
